// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - keyboard-driven shot sequencer for a two-player grid game
// Decodes PS/2 coordinates, then reads, marks and scores one target cell per turn.
module turn_sequencer #(
   parameter int BOARD_SIZE = 10,
   parameter int SHIP_CELLS = 17
) (
   input  logic       clock50,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   output logic       cell_player,
   output logic [3:0] cell_row,
   output logic [3:0] cell_col,
   output logic       cell_rd_en,
   input  logic [1:0] cell_rd_data,
   output logic       cell_wr_en,
   output logic [1:0] cell_wr_data,
   output logic       player_turn,
   output logic [4:0] hits_p1,
   output logic [4:0] hits_p2,
   output logic [1:0] shot_result,
   output logic       busy,
   output logic       game_over,
   output logic       winner
);

   typedef enum logic [2:0] {
      S_IDLE, S_GOT_ROW, S_ARMED, S_READ, S_EVAL, S_WRITE, S_SWITCH, S_DONE
   } state_t;

   localparam logic [4:0] HIT_MAX = 5'(SHIP_CELLS);

   state_t     state, state_nxt;
   logic       brk;
   logic       win_q;
   logic [3:0] row_q, col_q;
   logic [1:0] wr_data_q;
   logic [3:0] row_idx, col_idx;
   logic       row_hit, col_hit;
   logic       entry_state, key_take, key_act;
   logic       letter, digit, enter, esc;
   logic [4:0] fire_hits;

   always_comb begin
      row_hit = 1'b1;
      row_idx = 4'd0;
      case (key_code)
         8'h1C: row_idx = 4'd0;
         8'h32: row_idx = 4'd1;
         8'h21: row_idx = 4'd2;
         8'h23: row_idx = 4'd3;
         8'h24: row_idx = 4'd4;
         8'h2B: row_idx = 4'd5;
         8'h34: row_idx = 4'd6;
         8'h33: row_idx = 4'd7;
         8'h43: row_idx = 4'd8;
         8'h3B: row_idx = 4'd9;
         default: row_hit = 1'b0;
      endcase
   end

   always_comb begin
      col_hit = 1'b1;
      col_idx = 4'd0;
      case (key_code)
         8'h45: col_idx = 4'd0;
         8'h16: col_idx = 4'd1;
         8'h1E: col_idx = 4'd2;
         8'h26: col_idx = 4'd3;
         8'h25: col_idx = 4'd4;
         8'h2E: col_idx = 4'd5;
         8'h36: col_idx = 4'd6;
         8'h3D: col_idx = 4'd7;
         8'h3E: col_idx = 4'd8;
         8'h46: col_idx = 4'd9;
         default: col_hit = 1'b0;
      endcase
   end

   // Keys only count while entering a coordinate; break-prefix tracking is gated the same way.
   assign entry_state = (state == S_IDLE) || (state == S_GOT_ROW) || (state == S_ARMED);
   assign key_take    = key_valid && entry_state;
   assign key_act     = key_take && !brk && (key_code != 8'hF0);
   assign letter      = key_act && row_hit && (int'(row_idx) < BOARD_SIZE);
   assign digit       = key_act && col_hit && (int'(col_idx) < BOARD_SIZE);
   assign enter       = key_act && (key_code == 8'h5A);
   assign esc         = key_act && (key_code == 8'h76);
   assign fire_hits   = player_turn ? hits_p2 : hits_p1;

   always_ff @(posedge clock50 or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (letter) state_nxt = S_GOT_ROW;
         S_GOT_ROW: begin
            if (esc)        state_nxt = S_IDLE;
            else if (digit) state_nxt = S_ARMED;
         end
         S_ARMED: begin
            if (esc)         state_nxt = S_IDLE;
            else if (enter)  state_nxt = S_READ;
            else if (letter) state_nxt = S_GOT_ROW;
         end
         S_READ:    state_nxt = S_EVAL;
         S_EVAL:    state_nxt = cell_rd_data[1] ? S_IDLE : S_WRITE;
         S_WRITE:   state_nxt = S_SWITCH;
         S_SWITCH:  state_nxt = win_q ? S_DONE : S_IDLE;
         S_DONE:    state_nxt = S_DONE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   assign busy         = (state == S_READ) || (state == S_EVAL) ||
                         (state == S_WRITE) || (state == S_SWITCH);
   assign cell_rd_en   = (state == S_READ);
   assign cell_wr_en   = (state == S_WRITE);
   assign game_over    = (state == S_DONE);
   assign cell_player  = ~player_turn;
   assign cell_row     = row_q;
   assign cell_col     = col_q;
   assign cell_wr_data = wr_data_q;

   always_ff @(posedge clock50 or posedge reset) begin
      if (reset) begin
         brk         <= 1'b0;
         win_q       <= 1'b0;
         row_q       <= 4'd0;
         col_q       <= 4'd0;
         wr_data_q   <= 2'b00;
         player_turn <= 1'b0;
         hits_p1     <= 5'd0;
         hits_p2     <= 5'd0;
         shot_result <= 2'b00;
         winner      <= 1'b0;
      end else begin
         if (key_take) begin
            if (brk)                    brk <= 1'b0;
            else if (key_code == 8'hF0) brk <= 1'b1;
         end
         if (letter) begin
            row_q       <= row_idx;
            shot_result <= 2'b00;
         end
         if (digit && state != S_IDLE) col_q <= col_idx;
         if (esc && state != S_IDLE) begin
            row_q <= 4'd0;
            col_q <= 4'd0;
         end
         case (state)
            S_EVAL: begin
               win_q <= 1'b0;
               case (cell_rd_data)
                  2'b00: begin
                     wr_data_q   <= 2'b10;
                     shot_result <= 2'b10;
                  end
                  2'b01: begin
                     wr_data_q   <= 2'b11;
                     shot_result <= 2'b11;
                     if (!player_turn && hits_p1 < HIT_MAX) hits_p1 <= hits_p1 + 5'd1;
                     if (player_turn && hits_p2 < HIT_MAX)  hits_p2 <= hits_p2 + 5'd1;
                  end
                  default: shot_result <= 2'b01;
               endcase
            end
            // Turn flips at the end of the write so the new shooter shows during SWITCH.
            S_WRITE: begin
               if (fire_hits == HIT_MAX) win_q <= 1'b1;
               else                      player_turn <= ~player_turn;
            end
            S_SWITCH: if (win_q) winner <= player_turn;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - scoreboard bench for turn_sequencer
module tb_turn_sequencer;

   typedef struct {
      logic       wr;
      logic       pl;
      logic [3:0] r;
      logic [3:0] c;
      logic [1:0] d;
      int         cyc;
   } acc_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       key_valid = 1'b0;
   logic [7:0] key_code = 8'h00;
   logic       cell_player, cell_rd_en, cell_wr_en;
   logic [3:0] cell_row, cell_col;
   logic [1:0] cell_rd_data = 2'b00;
   logic [1:0] cell_wr_data;
   logic       player_turn, busy, game_over, winner;
   logic [4:0] hits_p1, hits_p2;
   logic [1:0] shot_result;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   int   cur_n = 0;
   acc_t sbq[$];
   acc_t mon_e;

   logic [1:0] ram [0:1][0:9][0:9];
   logic [1:0] eb  [0:1][0:9][0:9];
   logic [7:0] rowk [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
   logic [7:0] digk [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   logic       exp_turn = 1'b0;
   logic [4:0] exp_h1 = 5'd0, exp_h2 = 5'd0;
   logic [1:0] exp_shot = 2'b00;
   logic       exp_over = 1'b0, exp_win = 1'b0;

   turn_sequencer #(.BOARD_SIZE(10), .SHIP_CELLS(17)) dut (
      .clock50(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
      .cell_player(cell_player), .cell_row(cell_row), .cell_col(cell_col),
      .cell_rd_en(cell_rd_en), .cell_rd_data(cell_rd_data),
      .cell_wr_en(cell_wr_en), .cell_wr_data(cell_wr_data),
      .player_turn(player_turn), .hits_p1(hits_p1), .hits_p2(hits_p2),
      .shot_result(shot_result), .busy(busy), .game_over(game_over), .winner(winner)
   );

   always #10 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cell_rd_en) cell_rd_data <= ram[cell_player][cell_row][cell_col];
      if (cell_wr_en) ram[cell_player][cell_row][cell_col] <= cell_wr_data;
   end

   always @(negedge clk) begin
      if (cell_rd_en || cell_wr_en) begin
         checks++;
         if (cell_rd_en && cell_wr_en) begin
            errors++;
            $display("FAIL rd_wr_overlap at cyc %0d", cyc);
         end else if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_access wr=%0b pl=%0b r=%0d c=%0d cyc=%0d",
                     cell_wr_en, cell_player, cell_row, cell_col, cyc);
         end else begin
            mon_e = sbq.pop_front();
            if (mon_e.wr !== cell_wr_en || mon_e.pl !== cell_player || mon_e.r !== cell_row ||
                mon_e.c !== cell_col || mon_e.cyc != cyc || (mon_e.wr && mon_e.d !== cell_wr_data)) begin
               errors++;
               $display("FAIL access got wr=%0b pl=%0b r=%0d c=%0d d=%0b cyc=%0d expected wr=%0b pl=%0b r=%0d c=%0d d=%0b cyc=%0d",
                        cell_wr_en, cell_player, cell_row, cell_col, cell_wr_data, cyc,
                        mon_e.wr, mon_e.pl, mon_e.r, mon_e.c, mon_e.d, mon_e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] code);
      @(posedge clk);
      #1;
      key_valid = 1'b1;
      key_code  = code;
      last_cyc  = cyc;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
   endtask

   task automatic keys(input int r, input int c);
      send(rowk[r]);
      send(digk[c]);
      send(8'h5A);
   endtask

   // Pushes the accesses the shot just entered should cause and updates the expected game state.
   task automatic arm(input int r, input int c);
      acc_t       a;
      logic       tgt;
      logic [1:0] cur;
      tgt   = ~exp_turn;
      cur   = eb[tgt][r][c];
      cur_n = last_cyc;
      a.wr = 1'b0; a.pl = tgt; a.r = 4'(r); a.c = 4'(c); a.d = 2'b00; a.cyc = cur_n + 1;
      sbq.push_back(a);
      a.wr = 1'b1; a.cyc = cur_n + 3;
      case (cur)
         2'b00: begin
            a.d = 2'b10; sbq.push_back(a); eb[tgt][r][c] = 2'b10;
            exp_shot = 2'b10; exp_turn = ~exp_turn;
         end
         2'b01: begin
            a.d = 2'b11; sbq.push_back(a); eb[tgt][r][c] = 2'b11;
            exp_shot = 2'b11;
            if (tgt) exp_h1++; else exp_h2++;
            if ((tgt ? exp_h1 : exp_h2) == 5'd17) begin
               exp_over = 1'b1;
               exp_win  = ~tgt;
            end else begin
               exp_turn = ~exp_turn;
            end
         end
         default: exp_shot = 2'b01;
      endcase
   endtask

   task automatic finish_shot();
      wait_cyc(cur_n + 4);
      @(negedge clk);
      chk("turn_at_n4", player_turn, exp_turn);
      wait_cyc(cur_n + 6);
      @(negedge clk);
      chk("busy_after", busy, 1'b0);
      chk("shot_result", shot_result, exp_shot);
      chk("hits_p1", hits_p1, exp_h1);
      chk("hits_p2", hits_p2, exp_h2);
      chk("game_over", game_over, exp_over);
      chk("winner", winner, exp_win);
   endtask

   task automatic fire(input int r, input int c);
      keys(r, c);
      arm(r, c);
      finish_shot();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_turn"}, player_turn, 1'b0);
      chk({tag, "_h1"}, hits_p1, 5'd0);
      chk({tag, "_h2"}, hits_p2, 5'd0);
      chk({tag, "_shot"}, shot_result, 2'b00);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_over"}, game_over, 1'b0);
      chk({tag, "_winner"}, winner, 1'b0);
      chk({tag, "_rd"}, cell_rd_en, 1'b0);
      chk({tag, "_wr"}, cell_wr_en, 1'b0);
      chk({tag, "_row"}, cell_row, 4'd0);
      chk({tag, "_col"}, cell_col, 4'd0);
      chk({tag, "_player"}, cell_player, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) begin
               ram[p][r][c] = 2'b00;
               eb[p][r][c]  = 2'b00;
            end
      // Player two's fleet: E1, all of row A, C0..C5 -> 17 cells.
      ram[1][4][1] = 2'b01; eb[1][4][1] = 2'b01;
      for (int c = 0; c < 10; c++) begin ram[1][0][c] = 2'b01; eb[1][0][c] = 2'b01; end
      for (int c = 0; c < 6; c++)  begin ram[1][2][c] = 2'b01; eb[1][2][c] = 2'b01; end
      ram[0][0][0] = 2'b01; eb[0][0][0] = 2'b01;

      repeat (3) @(posedge clk);
      #5;
      check_reset("rst");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // E1 hit by player one, then a player-two miss, then a repeat shot on E1.
      fire(4, 1);
      fire(3, 3);
      fire(4, 1);

      // Break prefix swallows the second A; Escape clears; then B9.
      send(8'h1C); send(8'hF0); send(8'h1C); send(8'h45); send(8'h76);
      @(negedge clk);
      chk("esc_row", cell_row, 4'd0);
      chk("esc_col", cell_col, 4'd0);
      chk("esc_shot_cleared", shot_result, 2'b00);
      chk("esc_busy", busy, 1'b0);
      fire(1, 9);

      // Player two shoots J9 while keys, including a break prefix, arrive during the busy window.
      keys(9, 9);
      arm(9, 9);
      fork
         begin
            wait_cyc(cur_n + 2);
            key_valid = 1'b1; key_code = 8'h5A;
            wait_cyc(cur_n + 3);
            key_code = rowk[2];
            wait_cyc(cur_n + 4);
            key_code = 8'hF0;
            wait_cyc(cur_n + 5);
            key_valid = 1'b0;
         end
      join_none
      finish_shot();

      for (int i = 0; i < 16; i++) begin
         fire((i < 10) ? 0 : 2, (i < 10) ? i : i - 10);
         if (i < 15) fire(5 + i / 10, i % 10);
      end

      send(8'h1C); send(8'h45); send(8'h5A);
      wait_cyc(cyc + 8);
      @(negedge clk);
      chk("done_over", game_over, 1'b1);
      chk("done_winner", winner, 1'b0);
      chk("done_busy", busy, 1'b0);
      chk("done_row", cell_row, 4'd2);
      chk("done_col", cell_col, 4'd5);
      chk("done_shot", shot_result, 2'b11);
      chk("done_h1", hits_p1, 5'd17);

      @(posedge clk);
      #1;
      reset = 1'b1;
      wait_cyc(cyc + 2);
      reset = 1'b0;
      exp_turn = 1'b0; exp_h1 = 5'd0; exp_h2 = 5'd0; exp_shot = 2'b00;
      exp_over = 1'b0; exp_win = 1'b0;

      // Reset lands during EVAL of an H7 shot: only the read may appear.
      keys(7, 7);
      cur_n = last_cyc;
      mon_e.wr = 1'b0; mon_e.pl = 1'b1; mon_e.r = 4'd7; mon_e.c = 4'd7; mon_e.d = 2'b00;
      mon_e.cyc = cur_n + 1;
      sbq.push_back(mon_e);
      wait_cyc(cur_n + 2);
      #3;
      reset = 1'b1;
      #1;
      check_reset("mid");
      wait_cyc(cur_n + 5);
      reset = 1'b0;
      wait_cyc(cur_n + 10);
      @(negedge clk);
      chk("mid_cell_untouched", ram[1][7][7], 2'b00);
      chk("mid_busy", busy, 1'b0);
      chk("sb_empty", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
